// File: rtl/core_inst_seq_if.sv
// Handshake bundle between the tile controller, the instruction sequencer
// and the systolic core's instruction port.
interface core_inst_seq_if #(
    parameter int OIDX_W = 4
);
    logic              start;
    logic              ofifo_valid;
    logic [46:0]       inst;
    logic              acc_clr;
    logic              out_valid;
    logic [OIDX_W-1:0] out_idx;
    logic              busy;
    logic              done;

    // Controller / bench side: kicks off a tile and reports OFIFO occupancy.
    modport master (
        output start, ofifo_valid,
        input  inst, acc_clr, out_valid, out_idx, busy, done
    );

    // Sequencer side.
    modport slave (
        input  start, ofifo_valid,
        output inst, acc_clr, out_valid, out_idx, busy, done
    );
endinterface

// File: rtl/core_inst_seq.sv
// Instruction sequencer for one convolution tile of the systolic core.
// For every kernel offset kij it emits weight load/inject, intermission,
// activation load, execute and OFIFO drain into psum memory. It then walks
// every output pixel and accumulates the len_kij partial sums from psum memory.
// ofifo_valid is sampled at the clock edge that loads inst, so a transfer
// seen high at an edge becomes a psum write in the cycle that follows.
module core_inst_seq #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int in_w    = 6,
    parameter int k_w     = 3,
    parameter int gap     = 10,
    parameter int addr_bw = 11
) (
    input  logic           clk,
    input  logic           reset,
    core_inst_seq_if.slave bus
);
    localparam int LEN_NIJ  = in_w * in_w;
    localparam int LEN_KIJ  = k_w * k_w;
    localparam int OUT_W    = in_w - k_w + 1;
    localparam int LEN_ONIJ = OUT_W * OUT_W;
    localparam int EXEC_LEN = LEN_NIJ + row + col - 1;
    localparam int T_MAX    = EXEC_LEN + gap + LEN_KIJ;
    localparam int T_W      = $clog2(T_MAX + 1);
    localparam int K_W      = $clog2(LEN_KIJ + 1);
    localparam int O_W      = (LEN_ONIJ > 1) ? $clog2(LEN_ONIJ) : 1;
    localparam int OX_W     = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int KX_W     = (k_w > 1) ? $clog2(k_w) : 1;

    localparam logic [46:0] IDLE_WORD = 47'h6001_800C_0000;

    // Psum address steps: next kx moves one kij plane plus one pixel; a kx
    // wrap moves one plane plus down a row and back to the row start.
    localparam logic [addr_bw-1:0] KCOL_STEP = addr_bw'(LEN_NIJ + 1);
    localparam logic [addr_bw-1:0] KROW_STEP = addr_bw'(LEN_NIJ + in_w - k_w + 1);
    localparam logic [addr_bw-1:0] OROW_STEP = addr_bw'(k_w);

    typedef enum logic [3:0] {
        S_IDLE, S_W_LOAD, S_W_INJECT, S_GAP, S_X_L0, S_EXEC,
        S_DRAIN, S_OFIFO_RD, S_ACC_CLR, S_ACC_RD, S_ACC_OUT
    } state_t;

    state_t             r_state;
    logic [46:0]        r_inst;
    logic               r_acc_clr;
    logic               r_out_valid;
    logic [O_W-1:0]     r_out_idx;
    logic               r_busy;
    logic               r_done;
    logic [T_W-1:0]     r_t;       // cycle / transfer / j counter of the phase
    logic [K_W-1:0]     r_kij;
    logic [O_W-1:0]     r_o;
    logic [addr_bw-1:0] r_waddr;   // next wmem address, runs kij*col+t across kij
    logic [addr_bw-1:0] r_paddr;   // next psum write address, kij*len_nij+t
    logic [addr_bw-1:0] r_koff;    // kij_j*len_nij + ky*in_w + kx
    logic [KX_W-1:0]    r_kx;
    logic [addr_bw-1:0] r_obase;   // oy*in_w + ox
    logic [OX_W-1:0]    r_ox;
    logic [addr_bw-1:0] w_acc_addr;

    assign w_acc_addr = r_obase + r_koff;

    function automatic logic [46:0] f_wload(input logic [addr_bw-1:0] a);
        logic [46:0] w;
        w = IDLE_WORD;
        w[19] = 1'b0;
        w[17:7] = 11'(a);
        w[5] = 1'b1;
        return w;
    endfunction

    function automatic logic [46:0] f_xl0(input logic [addr_bw-1:0] a);
        logic [46:0] w;
        w = IDLE_WORD;
        w[46] = 1'b0;
        w[44:34] = 11'(a);
        w[2] = 1'b1;
        return w;
    endfunction

    function automatic logic [46:0] f_pmem(input logic [addr_bw-1:0] a, input logic wr,
                                           input logic rd_acc, input logic cen);
        logic [46:0] w;
        w = IDLE_WORD;
        w[33] = rd_acc;
        w[32] = cen;
        w[31] = ~wr;
        w[30:20] = 11'(a);
        w[6] = wr;
        return w;
    endfunction

    assign bus.inst      = r_inst;
    assign bus.acc_clr   = r_acc_clr;
    assign bus.out_valid = r_out_valid;
    assign bus.out_idx   = r_out_idx;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

    // Sequencer FSM: each branch loads the outputs for the cycle it enters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_inst      <= IDLE_WORD;
            r_acc_clr   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_t         <= '0;
            r_kij       <= '0;
            r_o         <= '0;
            r_waddr     <= '0;
            r_paddr     <= '0;
            r_koff      <= '0;
            r_kx        <= '0;
            r_obase     <= '0;
            r_ox        <= '0;
        end else begin
            // NOTE: pulses default low here so each branch only raises what it
            // needs; non-blocking updates keep every branch reading old state.
            r_acc_clr   <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_state <= S_W_LOAD;
                    r_busy  <= 1'b1;
                    r_t     <= '0;
                    r_kij   <= '0;
                    r_o     <= '0;
                    r_inst  <= f_wload('0);
                    r_waddr <= addr_bw'(1);
                    r_paddr <= '0;
                end
                S_W_LOAD: if (r_t == T_W'(col - 1)) begin
                    r_state <= S_W_INJECT;
                    r_t     <= '0;
                    r_inst  <= IDLE_WORD | 47'h11;
                end else begin
                    r_t     <= r_t + 1'b1;
                    r_inst  <= f_wload(r_waddr);
                    r_waddr <= r_waddr + 1'b1;
                end
                S_W_INJECT: if (r_t == T_W'(row + col - 2)) begin
                    r_state <= S_GAP;
                    r_t     <= '0;
                    r_inst  <= IDLE_WORD;
                end else begin
                    r_t <= r_t + 1'b1;
                end
                S_GAP: if (r_t == T_W'(gap - 1)) begin
                    r_state <= S_X_L0;
                    r_t     <= '0;
                    r_inst  <= f_xl0('0);
                end else begin
                    r_t <= r_t + 1'b1;
                end
                S_X_L0: if (r_t == T_W'(LEN_NIJ - 1)) begin
                    r_state <= S_EXEC;
                    r_t     <= '0;
                    r_inst  <= IDLE_WORD | 47'hA;
                end else begin
                    r_t    <= r_t + 1'b1;
                    r_inst <= f_xl0(addr_bw'(r_t + 1'b1));
                end
                S_EXEC: if (r_t == T_W'(EXEC_LEN - 1)) begin
                    r_state <= S_DRAIN;
                    r_t     <= '0;
                    r_inst  <= IDLE_WORD;
                end else begin
                    r_t <= r_t + 1'b1;
                end
                S_DRAIN: if (bus.ofifo_valid) begin
                    r_state <= S_OFIFO_RD;
                    r_t     <= T_W'(1);
                    r_inst  <= f_pmem(r_paddr, 1'b1, 1'b0, 1'b0);
                    r_paddr <= r_paddr + 1'b1;
                end
                S_OFIFO_RD: if (r_t == T_W'(LEN_NIJ)) begin
                    r_kij <= r_kij + 1'b1;
                    r_t   <= '0;
                    if (r_kij == K_W'(LEN_KIJ - 1)) begin
                        r_state   <= S_ACC_CLR;
                        r_acc_clr <= 1'b1;
                        r_inst    <= IDLE_WORD;
                        r_o       <= '0;
                        r_obase   <= '0;
                        r_ox      <= '0;
                        r_koff    <= '0;
                        r_kx      <= '0;
                    end else begin
                        r_state <= S_W_LOAD;
                        r_inst  <= f_wload(r_waddr);
                        r_waddr <= r_waddr + 1'b1;
                    end
                end else if (bus.ofifo_valid) begin
                    r_t     <= r_t + 1'b1;
                    r_inst  <= f_pmem(r_paddr, 1'b1, 1'b0, 1'b0);
                    r_paddr <= r_paddr + 1'b1;
                end else begin
                    // Stall: no write, psum address held from the last transfer.
                    r_inst <= f_pmem(r_inst[30:20], 1'b0, 1'b0, 1'b1);
                end
                S_ACC_CLR: begin
                    r_state <= S_ACC_RD;
                    r_t     <= '0;
                    r_inst  <= f_pmem(w_acc_addr, 1'b0, 1'b0, 1'b0);
                    if (r_kx == KX_W'(k_w - 1)) begin
                        r_kx   <= '0;
                        r_koff <= r_koff + KROW_STEP;
                    end else begin
                        r_kx   <= r_kx + 1'b1;
                        r_koff <= r_koff + KCOL_STEP;
                    end
                end
                S_ACC_RD: if (r_t == T_W'(LEN_KIJ)) begin
                    r_state     <= S_ACC_OUT;
                    r_inst      <= IDLE_WORD;
                    r_out_valid <= 1'b1;
                    r_out_idx   <= r_o;
                    r_done      <= (r_o == O_W'(LEN_ONIJ - 1));
                end else if (r_t == T_W'(LEN_KIJ - 1)) begin
                    // Last read's data returns now: accumulate without a read.
                    r_t    <= r_t + 1'b1;
                    r_inst <= f_pmem('0, 1'b0, 1'b1, 1'b1);
                end else begin
                    r_t    <= r_t + 1'b1;
                    r_inst <= f_pmem(w_acc_addr, 1'b0, 1'b1, 1'b0);
                    if (r_kx == KX_W'(k_w - 1)) begin
                        r_kx   <= '0;
                        r_koff <= r_koff + KROW_STEP;
                    end else begin
                        r_kx   <= r_kx + 1'b1;
                        r_koff <= r_koff + KCOL_STEP;
                    end
                end
                S_ACC_OUT: if (r_o == O_W'(LEN_ONIJ - 1)) begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_inst  <= IDLE_WORD;
                end else begin
                    r_state   <= S_ACC_CLR;
                    r_acc_clr <= 1'b1;
                    r_inst    <= IDLE_WORD;
                    r_o       <= r_o + 1'b1;
                    r_koff    <= '0;
                    r_kx      <= '0;
                    if (r_ox == OX_W'(OUT_W - 1)) begin
                        r_ox    <= '0;
                        r_obase <= r_obase + OROW_STEP;
                    end else begin
                        r_ox    <= r_ox + 1'b1;
                        r_obase <= r_obase + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_inst  <= IDLE_WORD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core_inst_seq.sv
// Scoreboard bench: a loop-nest model expands the whole tile into per-cycle
// expected records (with the ofifo_valid to present before each edge); the
// driver pops one record per cycle and compares the sequencer outputs.
module tb_core_inst_seq;
    localparam logic [46:0] IDLE_WORD = 47'h6001_800C_0000;

    typedef struct {
        logic        vld;
        logic [46:0] inst;
        logic        acc_clr;
        logic        out_valid;
        logic        done;
        logic        busy;
        int          idx;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_v = 1'b0;
    logic vld_v = 1'b0;
    logic sel = 1'b0;

    int checks = 0;
    int failures = 0;
    rec_t sb[$];
    int acc_q[$];
    int n_done, n_ov, n_wl;
    logic prev_wr;
    int exp_o0 [9];
    int exp_o5 [9];
    int exp_s3 [9];

    always #5 clk = ~clk;

    core_inst_seq_if #(.OIDX_W(4)) if_a ();
    core_inst_seq_if #(.OIDX_W(2)) if_b ();

    assign if_a.start       = start_v & ~sel;
    assign if_b.start       = start_v & sel;
    assign if_a.ofifo_valid = vld_v;
    assign if_b.ofifo_valid = vld_v;

    core_inst_seq u_dut_a (.clk(clk), .reset(reset), .bus(if_a));

    core_inst_seq #(.row(4), .col(4), .in_w(4), .k_w(3), .gap(10), .addr_bw(11))
        u_dut_b (.clk(clk), .reset(reset), .bus(if_b));

    logic [46:0] o_inst;
    logic [7:0]  o_idx;
    logic        o_acc_clr, o_out_valid, o_busy, o_done;

    // Observe whichever instance is under test.
    always_comb begin
        if (sel) begin
            o_inst = if_b.inst; o_idx = 8'(if_b.out_idx); o_acc_clr = if_b.acc_clr;
            o_out_valid = if_b.out_valid; o_busy = if_b.busy; o_done = if_b.done;
        end else begin
            o_inst = if_a.inst; o_idx = 8'(if_a.out_idx); o_acc_clr = if_a.acc_clr;
            o_out_valid = if_a.out_valid; o_busy = if_a.busy; o_done = if_a.done;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [46:0] w_wload(input int a);
        logic [46:0] w = IDLE_WORD;
        w[19] = 1'b0; w[17:7] = 11'(a); w[5] = 1'b1;
        return w;
    endfunction

    function automatic logic [46:0] w_xl0(input int a);
        logic [46:0] w = IDLE_WORD;
        w[46] = 1'b0; w[44:34] = 11'(a); w[2] = 1'b1;
        return w;
    endfunction

    function automatic logic [46:0] w_pwr(input int a);
        logic [46:0] w = IDLE_WORD;
        w[32] = 1'b0; w[31] = 1'b0; w[30:20] = 11'(a); w[6] = 1'b1;
        return w;
    endfunction

    function automatic logic [46:0] w_hold(input int a);
        logic [46:0] w = IDLE_WORD;
        w[30:20] = 11'(a);
        return w;
    endfunction

    function automatic logic [46:0] w_prd(input int a, input logic acc);
        logic [46:0] w = IDLE_WORD;
        w[33] = acc; w[32] = 1'b0; w[30:20] = 11'(a);
        return w;
    endfunction

    task automatic push(input logic v, input logic [46:0] w, input logic ac, input logic ov,
                        input logic dn, input logic bz, input int idx);
        rec_t r;
        r.vld = v; r.inst = w; r.acc_clr = ac; r.out_valid = ov;
        r.done = dn; r.busy = bz; r.idx = idx;
        sb.push_back(r);
    endtask

    // Expected per-cycle stream for one tile. With stalls set, kij 1 sees
    // ofifo_valid 1,0,0,1,... and kij 2 waits two extra cycles in drain.
    task automatic gen(input int row, input int col, input int in_w, input int k_w,
                       input int gap, input bit stalls);
        int len_nij, len_kij, out_w, len_onij, t, c, ex, last_a;
        logic [3:0] pat;
        len_nij = in_w * in_w;
        len_kij = k_w * k_w;
        out_w = in_w - k_w + 1;
        len_onij = out_w * out_w;
        pat = 4'b1001;
        for (int kij = 0; kij < len_kij; kij++) begin
            for (int i = 0; i < col; i++) push(1'b1, w_wload(kij * col + i), 0, 0, 0, 1, 0);
            for (int i = 0; i < row + col - 1; i++) push(1'b1, IDLE_WORD | 47'h11, 0, 0, 0, 1, 0);
            for (int i = 0; i < gap; i++) push(1'b1, IDLE_WORD, 0, 0, 0, 1, 0);
            for (int i = 0; i < len_nij; i++) push(1'b1, w_xl0(i), 0, 0, 0, 1, 0);
            for (int i = 0; i < len_nij + row + col - 1; i++) push(1'b1, IDLE_WORD | 47'hA, 0, 0, 0, 1, 0);
            ex = (stalls && kij == 2) ? 2 : 0;
            push(1'b1, IDLE_WORD, 0, 0, 0, 1, 0);
            for (int i = 0; i < ex; i++) push(1'b0, IDLE_WORD, 0, 0, 0, 1, 0);
            t = 0; c = 0; last_a = 0;
            while (t < len_nij) begin
                if (!stalls || kij != 1 || pat[c % 4]) begin
                    last_a = kij * len_nij + t;
                    push(1'b1, w_pwr(last_a), 0, 0, 0, 1, 0);
                    t++;
                end else begin
                    push(1'b0, w_hold(last_a), 0, 0, 0, 1, 0);
                end
                c++;
            end
        end
        for (int o = 0; o < len_onij; o++) begin
            int oy, ox;
            oy = o / out_w;
            ox = o % out_w;
            push(1'b1, IDLE_WORD, 1, 0, 0, 1, (o == 0) ? 0 : o - 1);
            for (int j = 0; j <= len_kij; j++) begin
                if (j < len_kij)
                    push(1'b1, w_prd(j * len_nij + (oy + j / k_w) * in_w + ox + j % k_w, j >= 1),
                         0, 0, 0, 1, (o == 0) ? 0 : o - 1);
                else
                    push(1'b1, IDLE_WORD | (47'b1 << 33), 0, 0, 0, 1, (o == 0) ? 0 : o - 1);
            end
            push(1'b1, IDLE_WORD, 0, 1, o == len_onij - 1, 1, o);
        end
        push(1'b1, IDLE_WORD, 0, 0, 0, 0, len_onij - 1);
    endtask

    // Pops one record per cycle; start pulses at record 0 and at start_at.
    task automatic run(input int abort_at, input int start_at);
        rec_t r;
        int n, base_fail;
        n = 0;
        base_fail = failures;
        acc_q.delete();
        n_done = 0; n_ov = 0; n_wl = 0; prev_wr = 1'b0;
        while (sb.size() > 0) begin
            if (n == abort_at || failures - base_fail >= 10) begin
                sb.delete();
                break;
            end
            r = sb.pop_front();
            vld_v = r.vld;
            start_v = (n == 0) || (n == start_at);
            @(posedge clk);
            #1;
            start_v = 1'b0;
            check("inst", 64'(o_inst), 64'(r.inst));
            check("flags", 64'({o_busy, o_acc_clr, o_out_valid, o_done, o_idx}),
                  64'({r.busy, r.acc_clr, r.out_valid, r.done, 8'(r.idx)}));
            if (!o_inst[32] && o_inst[31]) acc_q.push_back(int'(o_inst[30:20]));
            if (o_done) n_done++;
            if (o_out_valid) n_ov++;
            if (o_inst[5] && !prev_wr) n_wl++;
            prev_wr = o_inst[5];
            n++;
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        start_v = 1'b1;
        vld_v = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start_v = 1'b0;
        check({tag, "_inst"}, 64'(o_inst), 64'(IDLE_WORD));
        check({tag, "_flags"}, 64'({o_busy, o_acc_clr, o_out_valid, o_done, o_idx}), 64'(0));
        reset = 1'b0;
    endtask

    initial begin
        exp_o0 = '{0, 37, 74, 114, 151, 188, 228, 265, 302};
        exp_o5 = '{7, 44, 81, 121, 158, 195, 235, 272, 309};
        exp_s3 = '{5, 22, 39, 57, 74, 91, 109, 126, 143};

        // Default tile: reset, then abort partway through kij 0 execute.
        do_reset("rst_a");
        gen(8, 8, 6, 3, 10, 1'b0);
        run(8 + 15 + 10 + 36 + 20, -1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midexec_rst_inst", 64'(o_inst), 64'(IDLE_WORD));
        check("midexec_rst_busy", 64'(o_busy), 64'(0));
        reset = 1'b0;

        // Fresh full tile with OFIFO stalls and drain waits.
        gen(8, 8, 6, 3, 10, 1'b1);
        run(-1, -1);
        check("a_wload_phases", 64'(n_wl), 64'(9));
        check("a_out_valid", 64'(n_ov), 64'(16));
        check("a_done", 64'(n_done), 64'(1));
        check("a_acc_reads", 64'(acc_q.size()), 64'(144));
        for (int i = 0; i < 9; i++) begin
            check("a_o0_addr", 64'(acc_q[i]), 64'(exp_o0[i]));
            check("a_o5_addr", 64'(acc_q[45 + i]), 64'(exp_o5[i]));
        end

        // Small tile on the second instance; a start while busy is ignored.
        sel = 1'b1;
        do_reset("rst_b");
        gen(4, 4, 4, 3, 10, 1'b0);
        run(-1, 20);
        check("b_out_valid", 64'(n_ov), 64'(4));
        check("b_done", 64'(n_done), 64'(1));
        for (int i = 0; i < 9; i++) check("b_o3_addr", 64'(acc_q[27 + i]), 64'(exp_s3[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
